dmb_evt_fifo: RTL and testbench

//  Event-granular source FIFO feeding the DMB control readout sequencer (the CFEB/TMB/ALCT FIFO side).

---
 rtl/dmb_evt_fifo.sv | 185 ++++++++++++++++++
 tb/tb_dmb_evt_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmb_evt_fifo.sv
// dmb_evt_fifo
// Event-granular source FIFO for the DMB readout sequencer. The event builder
// writes 18-bit words framed by WLAST. The reader sees only complete events,
// through an active-low REN_B/OE_B/FFOR_B handshake with first-word fall-through.
// Three pointers: wptr (speculative write), cptr (committed end), rptr (read).
// An event that overflows is rolled back to cptr and its remaining words are
// discarded, so a partial event is never exposed.
// Optional build macro EVTFIFO_TRUNC_EN: an event that would overflow is kept,
// truncated with a TRUNC_WORD trailer in the last free slot.
module dmb_evt_fifo #(
    parameter int AW = 9
`ifdef EVTFIFO_TRUNC_EN
    ,
    parameter logic [17:0] TRUNC_WORD = 18'h3FFFF
`endif
) (
    input  logic          CLKDDU,
    input  logic          RST,
    input  logic          FIFOMRST,
    input  logic          WE,
    input  logic [17:0]   WDATA,
    input  logic          WLAST,
    input  logic          REN_B,
    input  logic          OE_B,
    output logic [17:0]   DOUT,
    output logic          DLAST,
    output logic          FFOR_B,
    output logic          FULL,
    output logic [AW:0]   EVCNT,
    output logic          OVFL,
    output logic          UNDR
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
`ifdef EVTFIFO_TRUNC_EN
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
`endif

    // Write-side framing states
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_FILL = 2'b01;
    localparam logic [1:0] S_DROP = 2'b10;

    logic [18:0] r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_cptr;
    logic [AW:0] r_rptr;
    logic [AW:0] r_evcnt;
    logic [1:0]  r_state;
    logic        r_ffor_b;
    logic        r_full;
    logic        r_ovfl;
    logic        r_undr;

    logic        w_clr;
    logic [AW:0] w_fill;
    logic [AW:0] w_avail;
    logic [18:0] w_head;
    logic        w_rd;
    logic        w_rd_last;
    logic        w_undr_set;
    logic [AW:0] w_rptr_nxt;
    logic        w_wr_en;
    logic [18:0] w_wr_word;
    logic [AW:0] w_wptr_nxt;
    logic [AW:0] w_cptr_nxt;
    logic        w_commit;
    logic        w_ovfl_set;
    logic [1:0]  w_state_nxt;
    logic [AW:0] w_evcnt_nxt;
    logic [AW:0] w_fill_nxt;

    assign w_clr      = RST | FIFOMRST;
    assign w_fill     = r_wptr - r_rptr;
    assign w_avail    = r_cptr - r_rptr;
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_rd       = !REN_B && (w_avail != '0);
    assign w_undr_set = !REN_B && (w_avail == '0);
    assign w_rd_last  = w_rd & w_head[18];
    assign w_rptr_nxt = r_rptr + (AW+1)'(w_rd);

    // Write framing: decide store / commit / rollback from the pre-edge fill level
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_word   = {WLAST, WDATA};
        w_wptr_nxt  = r_wptr;
        w_cptr_nxt  = r_cptr;
        w_commit    = 1'b0;
        w_ovfl_set  = 1'b0;
        w_state_nxt = r_state;
        if (WE) begin
            if (r_state == S_DROP) begin
                if (WLAST) begin
                    w_state_nxt = S_IDLE;
                end
            end else if (w_fill == DEPTH_W) begin
                // Discard the whole in-flight event. If this word already ends
                // the event there is nothing left to skip, so return to IDLE
                // rather than swallowing the next event.
                w_wptr_nxt  = r_cptr;
                w_ovfl_set  = 1'b1;
                w_state_nxt = WLAST ? S_IDLE : S_DROP;
            end
`ifdef EVTFIFO_TRUNC_EN
            else if ((w_fill == DEPTH_M1) && !WLAST) begin
                // Last free slot: close the event with the truncation trailer
                w_wr_en     = 1'b1;
                w_wr_word   = {1'b1, TRUNC_WORD};
                w_wptr_nxt  = r_wptr + ONE;
                w_cptr_nxt  = r_wptr + ONE;
                w_commit    = 1'b1;
                w_ovfl_set  = 1'b1;
                w_state_nxt = S_DROP;
            end
`endif
            else begin
                w_wr_en    = 1'b1;
                w_wptr_nxt = r_wptr + ONE;
                if (WLAST) begin
                    w_cptr_nxt  = r_wptr + ONE;
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
        end
    end

    assign w_evcnt_nxt = r_evcnt + (AW+1)'(w_commit) - (AW+1)'(w_rd_last);
    assign w_fill_nxt  = w_wptr_nxt - w_rptr_nxt;

    // Storage write port
    // NOTE: the array has no reset; only the pointers define what is valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge CLKDDU) begin
        if (w_wr_en && !w_clr) begin
            r_mem[r_wptr[AW-1:0]] <= w_wr_word;
        end
    end

    // Pointers, event count, framing state and registered status outputs
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLKDDU) begin
        if (w_clr) begin
            r_wptr   <= '0;
            r_cptr   <= '0;
            r_rptr   <= '0;
            r_evcnt  <= '0;
            r_state  <= S_IDLE;
            r_ffor_b <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_cptr   <= w_cptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_evcnt  <= w_evcnt_nxt;
            r_state  <= w_state_nxt;
            r_ffor_b <= (w_evcnt_nxt == '0);
            r_full   <= (w_fill_nxt == DEPTH_W);
        end
    end

    // Sticky error flags: cleared by RST only, held through FIFOMRST
    always_ff @(posedge CLKDDU) begin
        if (RST) begin
            r_ovfl <= 1'b0;
            r_undr <= 1'b0;
        end else if (!FIFOMRST) begin
            r_ovfl <= r_ovfl | w_ovfl_set;
            r_undr <= r_undr | w_undr_set;
        end
    end

    assign DOUT   = OE_B ? 18'h00000 : w_head[17:0];
    assign DLAST  = !OE_B & w_head[18];
    assign FFOR_B = r_ffor_b;
    assign FULL   = r_full;
    assign EVCNT  = r_evcnt;
    assign OVFL   = r_ovfl;
    assign UNDR   = r_undr;

endmodule

// File: tb/tb_dmb_evt_fifo.sv
// tb_dmb_evt_fifo
// Two instances share one clock: dut0 (AW=9, 512 words) and dut1 (AW=4, 16 words).
// A queue-based event model per instance predicts every output on each cycle.
// Directed literal checks pin the model to hand-computed values.
module tb_dmb_evt_fifo;

    logic clk;
    logic rst [2];
    logic mrst [2];
    logic we [2];
    logic [17:0] wdata [2];
    logic wlast [2];
    logic ren_b [2];
    logic oe_b [2];
    logic [17:0] dout [2];
    logic dlast [2];
    logic ffor_b [2];
    logic full [2];
    logic ovfl [2];
    logic undr [2];
    logic [9:0] evcnt0;
    logic [4:0] evcnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: committed words, pending words of the open event
    int          depth [2] = '{512, 16};
    logic [18:0] m_cq [2][$];
    logic [18:0] m_pq [2][$];
    bit          m_drop [2];
    bit          m_ovfl [2];
    bit          m_undr [2];
    bit          m_ffor [2];
    bit          m_full [2];
    bit          m_valid [2];
    int          m_ev [2];

    dmb_evt_fifo #(.AW(9)) u_dut0 (
        .CLKDDU(clk), .RST(rst[0]), .FIFOMRST(mrst[0]), .WE(we[0]), .WDATA(wdata[0]),
        .WLAST(wlast[0]), .REN_B(ren_b[0]), .OE_B(oe_b[0]), .DOUT(dout[0]), .DLAST(dlast[0]),
        .FFOR_B(ffor_b[0]), .FULL(full[0]), .EVCNT(evcnt0), .OVFL(ovfl[0]), .UNDR(undr[0])
    );

    dmb_evt_fifo #(.AW(4)) u_dut1 (
        .CLKDDU(clk), .RST(rst[1]), .FIFOMRST(mrst[1]), .WE(we[1]), .WDATA(wdata[1]),
        .WLAST(wlast[1]), .REN_B(ren_b[1]), .OE_B(oe_b[1]), .DOUT(dout[1]), .DLAST(dlast[1]),
        .FFOR_B(ffor_b[1]), .FULL(full[1]), .EVCNT(evcnt1), .OVFL(ovfl[1]), .UNDR(undr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] evcnt_of(input int id);
        return (id == 0) ? 32'(evcnt0) : 32'(evcnt1);
    endfunction

    // Apply pre-edge inputs to the model of one instance
    task automatic model_step(input int id);
        int fill;
        logic [18:0] w;
        if (rst[id] || mrst[id]) begin
            m_cq[id].delete();
            m_pq[id].delete();
            m_drop[id] = 1'b0;
            m_ev[id]   = 0;
            m_ffor[id] = 1'b1;
            m_full[id] = 1'b0;
            if (rst[id]) begin
                m_ovfl[id]  = 1'b0;
                m_undr[id]  = 1'b0;
                m_valid[id] = 1'b1;
            end
            return;
        end
        fill = m_cq[id].size() + m_pq[id].size();
        if (!ren_b[id]) begin
            if (m_cq[id].size() > 0) begin
                w = m_cq[id].pop_front();
                if (w[18]) m_ev[id]--;
            end else begin
                m_undr[id] = 1'b1;
            end
        end
        if (we[id]) begin
            if (m_drop[id]) begin
                if (wlast[id]) m_drop[id] = 1'b0;
            end else if (fill == depth[id]) begin
                m_pq[id].delete();
                m_ovfl[id] = 1'b1;
                m_drop[id] = !wlast[id];
            end
`ifdef EVTFIFO_TRUNC_EN
            else if (fill == depth[id] - 1 && !wlast[id]) begin
                for (int k = 0; k < m_pq[id].size(); k++) m_cq[id].push_back(m_pq[id][k]);
                m_cq[id].push_back({1'b1, 18'h3FFFF});
                m_pq[id].delete();
                m_ev[id]++;
                m_ovfl[id] = 1'b1;
                m_drop[id] = 1'b1;
            end
`endif
            else begin
                m_pq[id].push_back({wlast[id], wdata[id]});
                if (wlast[id]) begin
                    for (int k = 0; k < m_pq[id].size(); k++) m_cq[id].push_back(m_pq[id][k]);
                    m_pq[id].delete();
                    m_ev[id]++;
                end
            end
        end
        m_ffor[id] = (m_ev[id] == 0);
        m_full[id] = (m_cq[id].size() + m_pq[id].size() == depth[id]);
    endtask

    task automatic compare(input int id);
        string p;
        logic [18:0] h;
        if (!m_valid[id]) return;
        p = $sformatf("dut%0d", id);
        check({p, "_evcnt"},  evcnt_of(id),        32'(m_ev[id]));
        check({p, "_ffor_b"}, 32'(ffor_b[id]),     32'(m_ffor[id]));
        check({p, "_full"},   32'(full[id]),       32'(m_full[id]));
        check({p, "_ovfl"},   32'(ovfl[id]),       32'(m_ovfl[id]));
        check({p, "_undr"},   32'(undr[id]),       32'(m_undr[id]));
        if (oe_b[id]) begin
            check({p, "_dout_off"},  32'(dout[id]),  32'h0);
            check({p, "_dlast_off"}, 32'(dlast[id]), 32'h0);
        end else if (m_cq[id].size() > 0) begin
            h = m_cq[id][0];
            check({p, "_dout"},  32'(dout[id]),  32'(h[17:0]));
            check({p, "_dlast"}, 32'(dlast[id]), 32'(h[18]));
        end
    endtask

    // Single compare process: advance the model on the edge, compare just after it
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        compare(0);
        compare(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step(input int id, input bit w, input logic [17:0] d, input bit l, input bit rn);
        we[id]    = w;
        wdata[id] = d;
        wlast[id] = l;
        ren_b[id] = rn;
        tick();
        we[id]    = 1'b0;
        wlast[id] = 1'b0;
        ren_b[id] = 1'b1;
    endtask

    task automatic do_rst(input int id, input bit master);
        if (master) mrst[id] = 1'b1;
        else        rst[id]  = 1'b1;
        tick();
        mrst[id] = 1'b0;
        rst[id]  = 1'b0;
    endtask

    initial begin
        int n_last;
        bit rn;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; mrst[k] = 1'b0; we[k] = 1'b0; wdata[k] = '0;
            wlast[k] = 1'b0; ren_b[k] = 1'b1; oe_b[k] = 1'b0;
        end
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check("rst_evcnt",  32'(evcnt0),    32'd0);
        check("rst_ffor_b", 32'(ffor_b[0]), 32'd1);
        check("rst_full",   32'(full[0]),   32'd0);
        check("rst_ovfl",   32'(ovfl[0]),   32'd0);
        check("rst_undr",   32'(undr[0]),   32'd0);

        // Test 1: one 3-word event, visible only once complete
        step(0, 1, 18'h00001, 0, 1);
        step(0, 1, 18'h00002, 0, 1);
        check("t1_partial_evcnt",  32'(evcnt0),    32'd0);
        check("t1_partial_ffor_b", 32'(ffor_b[0]), 32'd1);
        step(0, 1, 18'h10003, 1, 1);
        check("t1_commit_evcnt",  32'(evcnt0),    32'd1);
        check("t1_commit_ffor_b", 32'(ffor_b[0]), 32'd0);
        oe_b[0] = 1'b1;
        #1;
        check("t1_oe_off_dout",  32'(dout[0]),  32'h0);
        check("t1_oe_off_dlast", 32'(dlast[0]), 32'h0);
        oe_b[0] = 1'b0;
        #1;
        check("t1_word0", 32'(dout[0]), 32'h00001);
        check("t1_last0", 32'(dlast[0]), 32'd0);
        step(0, 0, '0, 0, 0);
        check("t1_word1", 32'(dout[0]), 32'h00002);
        step(0, 0, '0, 0, 0);
        check("t1_word2", 32'(dout[0]), 32'h10003);
        check("t1_last2", 32'(dlast[0]), 32'd1);
        step(0, 0, '0, 0, 0);
        check("t1_drain_evcnt",  32'(evcnt0),    32'd0);
        check("t1_drain_ffor_b", 32'(ffor_b[0]), 32'd1);

        // Test 3: underrun on empty FIFO; FIFOMRST keeps UNDR, RST clears it
        do_rst(0, 0);
        check("t3_head_after_rst", 32'(dout[0]), 32'h00001);
        step(0, 0, '0, 0, 0);
        check("t3_undr_set",  32'(undr[0]), 32'd1);
        check("t3_dout_held", 32'(dout[0]), 32'h00001);
        do_rst(0, 1);
        check("t3_undr_mrst", 32'(undr[0]), 32'd1);
        do_rst(0, 0);
        check("t3_undr_rst",  32'(undr[0]), 32'd0);

        // Test 4: last word of event A read in the cycle event B commits
        step(0, 1, 18'h00011, 0, 1);
        step(0, 1, 18'h00012, 1, 1);
        step(0, 0, '0, 0, 0);
        step(0, 1, 18'h00021, 0, 1);
        step(0, 1, 18'h00022, 1, 0);
        check("t4_evcnt_same",  32'(evcnt0),    32'd1);
        check("t4_ffor_b_same", 32'(ffor_b[0]), 32'd0);
        check("t4_next_head",   32'(dout[0]),   32'h00021);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        check("t4_drain_evcnt", 32'(evcnt0), 32'd0);

        // Test 5: 17-word events streamed with concurrent reads; enough words to wrap the full pointer
        n_last = 0;
        for (int e = 0; e < 64; e++) begin
            for (int i = 0; i < 17; i++) begin
                rn = (m_cq[0].size() == 0);
                if (!rn && dlast[0]) n_last++;
                step(0, 1, 18'((e << 8) | i), (i == 16), rn);
            end
        end
        for (int n = 0; n < 2000 && m_cq[0].size() > 0; n++) begin
            if (dlast[0]) n_last++;
            step(0, 0, '0, 0, 0);
        end
        check("t5_drained",    32'(m_cq[0].size()), 32'd0);
        check("t5_events_out", 32'(n_last),          32'd64);
        check("t5_evcnt",      32'(evcnt0),          32'd0);
        check("t5_no_ovfl",    32'(ovfl[0]),         32'd0);

        // Test 6: reset in the middle of an event discards it
        for (int i = 0; i < 5; i++) step(0, 1, 18'(16'h0040 + i), 0, 1);
        do_rst(0, 0);
        check("t6_evcnt",  32'(evcnt0),    32'd0);
        check("t6_ffor_b", 32'(ffor_b[0]), 32'd1);
        step(0, 1, 18'h00031, 0, 1);
        step(0, 1, 18'h00032, 0, 1);
        step(0, 1, 18'h00033, 1, 1);
        check("t6_word0", 32'(dout[0]), 32'h00031);
        step(0, 0, '0, 0, 0);
        check("t6_word1", 32'(dout[0]), 32'h00032);
        step(0, 0, '0, 0, 0);
        check("t6_word2", 32'(dout[0]), 32'h00033);
        check("t6_last2", 32'(dlast[0]), 32'd1);
        step(0, 0, '0, 0, 0);

        // Test 2 (16-word instance): second 10-word event overflows
        for (int i = 0; i < 10; i++) step(1, 1, 18'(256 + i), (i == 9), 1);
        check("t2_first_evcnt", 32'(evcnt1), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 18'(512 + i), (i == 9), 1);
`ifndef EVTFIFO_TRUNC_EN
            if (i == 5) check("t2_full_at_16", 32'(full[1]), 32'd1);
`endif
        end
        check("t2_ovfl", 32'(ovfl[1]), 32'd1);
`ifdef EVTFIFO_TRUNC_EN
        check("t2_evcnt", 32'(evcnt1),  32'd2);
        check("t2_full",  32'(full[1]), 32'd1);
`else
        check("t2_evcnt", 32'(evcnt1),  32'd1);
        check("t2_full",  32'(full[1]), 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_ev1_word%0d", i), 32'(dout[1]),  32'(256 + i));
            check($sformatf("t2_ev1_last%0d", i), 32'(dlast[1]), 32'(i == 9));
            step(1, 0, '0, 0, 0);
        end
`ifdef EVTFIFO_TRUNC_EN
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_ev2_word%0d", i), 32'(dout[1]),  (i < 5) ? 32'(512 + i) : 32'h3FFFF);
            check($sformatf("t2_ev2_last%0d", i), 32'(dlast[1]), 32'(i == 5));
            step(1, 0, '0, 0, 0);
        end
`endif
        check("t2_drain_evcnt",  32'(evcnt1),    32'd0);
        check("t2_drain_ffor_b", 32'(ffor_b[1]), 32'd1);
        // Recovery: a following event is stored normally
        for (int i = 0; i < 3; i++) step(1, 1, 18'(768 + i), (i == 2), 1);
        check("t2_recover_evcnt", 32'(evcnt1), 32'd1);
        check("t2_recover_head",  32'(dout[1]), 32'h00300);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);
        check("t2_recover_drain", 32'(evcnt1), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
